// File: rtl/edge_event_pkg.sv
// rtl/edge_event_pkg.sv - shared mode and arbiter state types for the edge event arbiter
package edge_event_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_RISE  = 2'b01,
    MODE_FALL  = 2'b10,
    MODE_PULSE = 2'b11
  } mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/edge_event_det.sv
// rtl/edge_event_det.sv - two-deep input history plus mode-selected edge/pulse detect for one channel
module edge_event_det
  import edge_event_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  sig,
  input  mode_t mode,
  output logic  det
);

  logic h0;
  logic h1;

  // History runs every cycle independent of mode so a mode switch sees real past values.
  always_ff @(posedge clk) begin
    if (rst) begin
      h0 <= 1'b0;
      h1 <= 1'b0;
    end else begin
      h0 <= sig;
      h1 <= h0;
    end
  end

  always_comb begin
    det = 1'b0;
    case (mode)
      MODE_OFF:   det = 1'b0;
      MODE_RISE:  det = ~h0 & sig;
      MODE_FALL:  det = h0 & ~sig;
      MODE_PULSE: det = ~h1 & h0 & ~sig;
      default:    det = 1'b0;
    endcase
  end

endmodule

// File: rtl/edge_event_arbiter.sv
// rtl/edge_event_arbiter.sv - per-channel event detect, pending latch and round-robin report arbiter
// Sticky lost-event flags are built only when EDGE_EVENT_ARB_OVERFLOW_EN is defined.
module edge_event_arbiter
  import edge_event_pkg::*;
#(
  parameter int N_CH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         sig_in,
  input  logic [2*N_CH-1:0]       mode,
  input  logic                    ovf_clr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(N_CH)-1:0] out_ch,
  output logic [N_CH-1:0]         overflow
);

  localparam int CW = $clog2(N_CH);

  logic [N_CH-1:0] det;
  logic [N_CH-1:0] pending;
  logic [N_CH-1:0] clr_mask;
  logic [CW-1:0]   last_grant;
  logic [CW-1:0]   grant_ch;
  logic [CW-1:0]   rr_idx;
  logic            grant_any;
  logic            grant_fire;
  state_t          state;
  state_t          state_nxt;

  for (genvar i = 0; i < N_CH; i++) begin : g_det
    edge_event_det u_det (
      .clk  (clk),
      .rst  (rst),
      .sig  (sig_in[i]),
      .mode (mode_t'(mode[2*i +: 2])),
      .det  (det[i])
    );
  end

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    grant_any = 1'b0;
    grant_ch  = '0;
    rr_idx    = '0;
    for (int k = 1; k <= N_CH; k++) begin
      rr_idx = CW'((int'(last_grant) + k) % N_CH);
      if (!grant_any && pending[rr_idx]) begin
        grant_any = 1'b1;
        grant_ch  = rr_idx;
      end
    end
  end

  assign grant_fire = (state == ST_IDLE) && grant_any;

  always_comb begin
    clr_mask = '0;
    if (grant_fire) clr_mask[grant_ch] = 1'b1;
  end

  // A fresh detect on the channel being granted re-arms it rather than being lost.
  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= (pending & ~clr_mask) | det;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (grant_any) state_nxt = ST_HOLD;
      ST_HOLD: if (out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state == ST_HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_ch     <= '0;
      last_grant <= CW'(N_CH - 1);
    end else if (grant_fire) begin
      out_ch     <= grant_ch;
      last_grant <= grant_ch;
    end
  end

`ifdef EDGE_EVENT_ARB_OVERFLOW_EN
  logic [N_CH-1:0] ovf_q;
  logic [N_CH-1:0] merge;

  assign merge = det & pending & ~clr_mask;

  // A new lost event in the same cycle as a clear still lands.
  always_ff @(posedge clk) begin
    if (rst) ovf_q <= '0;
    else     ovf_q <= (ovf_clr ? '0 : ovf_q) | merge;
  end

  assign overflow = ovf_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign overflow       = '0;
`endif

endmodule
